// File: rtl/averager_counter_seq_if.sv
// averager_counter_seq_if
// Bundles the sample strobe, control/config inputs and status outputs of the
// averager sequencing core.
//   master : software/ADC side (drives clken, restart, config, trig, avg_on)
//   slave  : sequencer core (drives ready, wen, valid, address, counters, flags)
interface averager_counter_seq_if #(
  parameter int FAST_COUNT_WIDTH = 13,
  parameter int SLOW_COUNT_WIDTH = 19,
  parameter int ADDR_SHIFT       = 2
);
  logic                                   clken;
  logic                                   restart;
  logic [FAST_COUNT_WIDTH-1:0]            count_max;
  logic [SLOW_COUNT_WIDTH-1:0]            n_avg_target;
  logic                                   trig_mode;
  logic                                   trig;
  logic                                   avg_on;
  logic                                   ready;
  logic                                   wen;
  logic                                   valid;
  logic [FAST_COUNT_WIDTH+ADDR_SHIFT-1:0] address;
  logic [SLOW_COUNT_WIDTH-1:0]            slow_count;
  logic [SLOW_COUNT_WIDTH-1:0]            n_avg;
  logic                                   clr_fback;
  logic                                   avg_on_out;
  logic                                   done;
  logic                                   ovf;

  modport master (
    output clken, restart, count_max, n_avg_target, trig_mode, trig, avg_on,
    input  ready, wen, valid, address, slow_count, n_avg, clr_fback,
           avg_on_out, done, ovf
  );

  modport slave (
    input  clken, restart, count_max, n_avg_target, trig_mode, trig, avg_on,
    output ready, wen, valid, address, slow_count, n_avg, clr_fback,
           avg_on_out, done, ovf
  );
endinterface

// File: rtl/averager_counter_seq.sv
// averager_counter_seq
// Timing/sequencing core of the BRAM feedback averager. Generates the
// per-sample accumulator address, counts accumulated periods and decides when
// the accumulated record is written out (restart, auto-stop or trigger-gated).
// Ports:
//   clk   : clock, all logic on posedge
//   srst  : synchronous active-high reset
//   bus   : averager_counter_seq_if.slave (strobe, config, status)
//
// state | meaning
// ACC   | accumulating periods, wen=0
// WRITE | result-write period, wen=1
module averager_counter_seq #(
  parameter int FAST_COUNT_WIDTH = 13,
  parameter int SLOW_COUNT_WIDTH = 19,
  parameter int CLKEN_DELAY      = 2,
  parameter int ADDR_SHIFT       = 2,
  parameter int CLR_LEAD         = 2
) (
  input logic clk,
  input logic srst,
  averager_counter_seq_if.slave bus
);
  localparam int AW  = FAST_COUNT_WIDTH + ADDR_SHIFT;
  localparam int SW1 = SLOW_COUNT_WIDTH + 1;

  typedef enum logic {ACC, WRITE} state_t;

  state_t                      state;
  logic [CLKEN_DELAY-1:0]      ce_pipe;
  logic [FAST_COUNT_WIDTH-1:0] fast_count;
  logic [FAST_COUNT_WIDTH-1:0] count_max_reg;
  logic                        trig_mode_reg;
  logic                        wait_trig;
  logic                        pending;
  logic                        avg_stage0;
  logic                        avg_stage1;

  logic                        ce;
  logic                        at_end;
  logic                        period_end;
  logic                        clr_point;
  logic                        slow_full;
  logic [SLOW_COUNT_WIDTH-1:0] slow_next;
  logic [SW1-1:0]              slow_plus2;
  logic                        go;

  assign ce         = ce_pipe[CLKEN_DELAY-1];
  assign at_end     = (fast_count == count_max_reg);
  assign period_end = ce & ~wait_trig & at_end;
  assign clr_point  = ce & (fast_count == count_max_reg - FAST_COUNT_WIDTH'(CLR_LEAD));
  assign slow_full  = &bus.slow_count;
  assign slow_next  = slow_full ? bus.slow_count : bus.slow_count + SLOW_COUNT_WIDTH'(1);
  // One extra bit so slow_count+2 cannot wrap near all-ones. Uses the
  // pre-increment count: the period now ending is the (slow_count+1)th,
  // and the write period that follows is counted too.
  assign slow_plus2 = {1'b0, bus.slow_count} + SW1'(2);
  // pending is the registered flag, so a restart landing on this very
  // period_end only takes effect at the next one.
  assign go         = pending | ((bus.n_avg_target != '0) &&
                                 (slow_plus2 >= {1'b0, bus.n_avg_target}));

  // While waiting for a trigger the strobe carrying trig is sample 0.
  assign bus.valid   = ce & (~wait_trig | bus.trig);
  assign bus.address = AW'(fast_count) << ADDR_SHIFT;

  always_ff @(posedge clk) begin
    if (srst) begin
      state          <= ACC;
      ce_pipe        <= '0;
      fast_count     <= '0;
      count_max_reg  <= '1;
      trig_mode_reg  <= 1'b0;
      wait_trig      <= 1'b0;
      pending        <= 1'b0;
      avg_stage0     <= 1'b0;
      avg_stage1     <= 1'b0;
      bus.ready      <= 1'b1;
      bus.wen        <= 1'b0;
      bus.slow_count <= '0;
      bus.n_avg      <= '0;
      bus.clr_fback  <= 1'b0;
      bus.avg_on_out <= 1'b0;
      bus.done       <= 1'b0;
      bus.ovf        <= 1'b0;
    end else begin
      ce_pipe[0] <= bus.clken;
      for (int i = 1; i < CLKEN_DELAY; i++) ce_pipe[i] <= ce_pipe[i-1];

      bus.done <= 1'b0;

      if (ce) begin
        if (wait_trig) begin
          if (bus.trig) begin
            wait_trig  <= 1'b0;
            fast_count <= FAST_COUNT_WIDTH'(1);
          end
        end else if (at_end) begin
          fast_count <= '0;
          if (trig_mode_reg) wait_trig <= 1'b1;
        end else begin
          fast_count <= fast_count + FAST_COUNT_WIDTH'(1);
        end
      end

      case (state)
        ACC: begin
          if (bus.restart & ce & bus.ready) begin
            pending   <= 1'b1;
            bus.ready <= 1'b0;
          end
          if (period_end) begin
            bus.slow_count <= slow_next;
            if (slow_full) bus.ovf <= 1'b1;
            // Overrides a same-cycle restart so auto-stop + restart is one write.
            if (go) begin
              state     <= WRITE;
              bus.wen   <= 1'b1;
              pending   <= 1'b0;
              bus.ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          // avg_on is staged twice: the value sampled now governs the next
          // accumulation, and is reported one write later.
          if (clr_point) begin
            bus.clr_fback <= ~bus.avg_on;
            avg_stage0    <= bus.avg_on;
            avg_stage1    <= avg_stage0;
          end
          if (period_end) begin
            bus.n_avg      <= slow_next;
            bus.slow_count <= '0;
            bus.wen        <= 1'b0;
            bus.ready      <= 1'b1;
            bus.done       <= 1'b1;
            count_max_reg  <= bus.count_max;
            trig_mode_reg  <= bus.trig_mode;
            bus.avg_on_out <= avg_stage1;
            state          <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule
